// File: rtl/tx_ctrl_pkg.sv
// Shared types for the TX control slice: sequencer state, configuration record, scale limit.
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_DOWN = 2'd1,
    APPLY     = 2'd2,
    RAMP_UP   = 2'd3
  } tx_seq_state_t;

  typedef struct packed {
    logic [7:0]  gain;
    logic [15:0] phase_inc;
    logic        pre_distortion;
    logic [3:0]  scale;
  } tx_cfg_t;

  localparam logic [3:0] SCALE_MAX = 4'd15;

endpackage

// File: rtl/tx_auto_scale.sv
// Auto-scale observer: per-window peak of interval_max with over/under hysteresis.
// Emits single-cycle step requests; the sequencer owns scale_select itself.
module tx_auto_scale
  import tx_ctrl_pkg::*;
#(
  parameter int          WINDOW_LEN = 1024,
  parameter logic [15:0] HIGH_THR   = 16'd30000,
  parameter logic [15:0] LOW_THR    = 16'd8000,
  parameter int          HYST       = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic        clr,
  input  logic [15:0] interval_max,
  input  logic [3:0]  scale_cur,
  output logic        step_up,
  output logic        step_down
);

  localparam int CW = $clog2(WINDOW_LEN);
  localparam int HW = $clog2(HYST + 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_LEN - 1);
  localparam logic [HW-1:0] HYST_N   = HW'(HYST);

  logic [CW-1:0] win_q, win_d;
  logic [15:0]   max_q, max_d, max_now;
  logic [HW-1:0] over_q, over_d, under_q, under_d;
  logic          win_end;

  always_comb begin
    max_now   = (interval_max > max_q) ? interval_max : max_q;
    win_end   = run && (win_q == WIN_LAST);
    win_d     = '0;
    max_d     = '0;
    over_d    = over_q;
    under_d   = under_q;
    step_up   = 1'b0;
    step_down = 1'b0;
    // Leaving run (outside IDLE, or on a handshake) restarts the window from zero.
    if (run && !win_end) begin
      win_d = win_q + 1'b1;
      max_d = max_now;
    end
    if (clr) begin
      over_d  = '0;
      under_d = '0;
    end else if (win_end) begin
      if (max_now > HIGH_THR) begin
        under_d = '0;
        over_d  = (over_q == HYST_N) ? HYST_N : over_q + 1'b1;
        if (over_d == HYST_N && scale_cur != SCALE_MAX) begin
          step_up = 1'b1;
          over_d  = '0;
        end
      end else if (max_now < LOW_THR) begin
        over_d  = '0;
        under_d = (under_q == HYST_N) ? HYST_N : under_q + 1'b1;
        if (under_d == HYST_N && scale_cur != 4'd0) begin
          step_down = 1'b1;
          under_d   = '0;
        end
      end else begin
        over_d  = '0;
        under_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      win_q   <= '0;
      max_q   <= '0;
      over_q  <= '0;
      under_q <= '0;
    end else begin
      win_q   <= win_d;
      max_q   <= max_d;
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

endmodule

// File: rtl/tx_cfg_sequencer.sv
// TX configuration sequencer: ramps mixer gain to zero, swaps LO/pre-distortion/scale in one
// cycle, ramps back to target. The auto-scale loop is built only with TX_AUTO_SCALE_EN.
// Handshake: a request is taken on any cycle with cfg_valid && cfg_ready; cfg_ready is high
// only in IDLE and the requester holds its fields stable until that cycle.
module tx_cfg_sequencer
  import tx_ctrl_pkg::*;
#(
  parameter int          RAMP_DIV   = 16,
  parameter int          GAIN_STEP  = 8,
  parameter int          WINDOW_LEN = 1024,
  parameter logic [15:0] HIGH_THR   = 16'd30000,
  parameter logic [15:0] LOW_THR    = 16'd8000,
  parameter int          HYST       = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [7:0]    cfg_gain,
  input  logic [15:0]   cfg_phase_inc,
  input  logic          cfg_pre_distortion,
  input  logic [3:0]    cfg_scale,
  input  logic [15:0]   interval_max,
  output logic [7:0]    mixer_gain,
  output logic [15:0]   lo_dds_phase_inc,
  output logic          enable_pre_distortion,
  output logic [3:0]    scale_select,
  output logic          busy,
  output logic          scale_event,
  output tx_seq_state_t dbg_state
);

  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
  localparam logic [7:0]    STEP8    = 8'(GAIN_STEP);
  localparam logic [8:0]    STEP9    = 9'(GAIN_STEP);

  tx_seq_state_t state_q, state_d;
  tx_cfg_t       shadow_q, shadow_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    gain_q, gain_d;
  logic [15:0]   phase_q, phase_d;
  logic          pd_q, pd_d;
  logic [3:0]    scale_q, scale_d;
  logic          event_q, event_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          hs, div_tick;
  logic [8:0]    gain_up9;
  logic          as_up, as_dn;

`ifdef TX_AUTO_SCALE_EN
  tx_auto_scale #(
    .WINDOW_LEN(WINDOW_LEN),
    .HIGH_THR  (HIGH_THR),
    .LOW_THR   (LOW_THR),
    .HYST      (HYST)
  ) u_auto_scale (
    .clock       (clock),
    .resetn      (resetn),
    .run         ((state_q == IDLE) && !cfg_valid),
    .clr         (state_q == APPLY),
    .interval_max(interval_max),
    .scale_cur   (scale_q),
    .step_up     (as_up),
    .step_down   (as_dn)
  );
`else
  logic unused_interval_max;
  assign unused_interval_max = ^interval_max;
  assign as_up = 1'b0;
  assign as_dn = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    div_d    = div_q;
    gain_d   = gain_q;
    phase_d  = phase_q;
    pd_d     = pd_q;
    scale_d  = scale_q;
    event_d  = 1'b0;
    hs       = cfg_valid && (state_q == IDLE);
    div_tick = (div_q == '0);
    gain_up9 = {1'b0, gain_q} + STEP9;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          shadow_d = '{gain: cfg_gain, phase_inc: cfg_phase_inc,
                       pre_distortion: cfg_pre_distortion, scale: cfg_scale};
          div_d    = DIV_LAST;
          state_d  = RAMP_DOWN;
        end else if (as_up) begin
          scale_d = scale_q + 4'd1;
          event_d = 1'b1;
        end else if (as_dn) begin
          scale_d = scale_q - 4'd1;
          event_d = 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (gain_q == 8'd0) begin
          state_d = APPLY;
        end else if (div_tick) begin
          gain_d = (gain_q > STEP8) ? gain_q - STEP8 : 8'd0;
          div_d  = DIV_LAST;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      APPLY: begin
        phase_d = shadow_q.phase_inc;
        pd_d    = shadow_q.pre_distortion;
        scale_d = shadow_q.scale;
        div_d   = DIV_LAST;
        state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (gain_q == shadow_q.gain) begin
          state_d = IDLE;
        end else if (div_tick) begin
          // 9-bit sum so the last step clips to target instead of wrapping.
          gain_d = (gain_up9 >= {1'b0, shadow_q.gain}) ? shadow_q.gain : gain_up9[7:0];
          div_d  = DIV_LAST;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      div_q    <= '0;
      gain_q   <= '0;
      phase_q  <= '0;
      pd_q     <= 1'b0;
      scale_q  <= '0;
      event_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      gain_q   <= gain_d;
      phase_q  <= phase_d;
      pd_q     <= pd_d;
      scale_q  <= scale_d;
      event_q  <= event_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign cfg_ready             = ready_q;
  assign busy                  = busy_q;
  assign mixer_gain            = gain_q;
  assign lo_dds_phase_inc      = phase_q;
  assign enable_pre_distortion = pd_q;
  assign scale_select          = scale_q;
  assign scale_event           = event_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_tx_cfg_sequencer.sv
// Directed bench for tx_cfg_sequencer: gain ramps scoreboarded with step values and cycles,
// APPLY timing, handshake hold, auto-scale behaviour (expectations follow TX_AUTO_SCALE_EN).
module tb_tx_cfg_sequencer;
  import tx_ctrl_pkg::*;

  localparam int DIV  = 16;
  localparam int STEP = 8;
  localparam int WL   = 64;
`ifdef TX_AUTO_SCALE_EN
  localparam logic [3:0] OVL_SCALE = 4'd4;
  localparam int         OVL_EV    = 1;
`else
  localparam logic [3:0] OVL_SCALE = 4'd3;
  localparam int         OVL_EV    = 0;
`endif

  logic          clock = 1'b0;
  logic          resetn;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [7:0]    cfg_gain;
  logic [15:0]   cfg_phase_inc;
  logic          cfg_pre_distortion;
  logic [3:0]    cfg_scale;
  logic [15:0]   interval_max;
  logic [7:0]    mixer_gain;
  logic [15:0]   lo_dds_phase_inc;
  logic          enable_pre_distortion;
  logic [3:0]    scale_select;
  logic          busy;
  logic          scale_event;
  tx_seq_state_t dbg_state;

  tx_cfg_sequencer #(
    .RAMP_DIV(DIV), .GAIN_STEP(STEP), .WINDOW_LEN(WL),
    .HIGH_THR(16'd30000), .LOW_THR(16'd8000), .HYST(3)
  ) dut (
    .clock(clock), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_gain(cfg_gain), .cfg_phase_inc(cfg_phase_inc),
    .cfg_pre_distortion(cfg_pre_distortion), .cfg_scale(cfg_scale),
    .interval_max(interval_max), .mixer_gain(mixer_gain),
    .lo_dds_phase_inc(lo_dds_phase_inc), .enable_pre_distortion(enable_pre_distortion),
    .scale_select(scale_select), .busy(busy), .scale_event(scale_event),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard state: {expected cycle, expected gain}
  logic [39:0] exp_q[$];
  int n_pass = 0, n_total = 0;
  int busy_bad = 0, ev_cnt = 0, txn_lo = 0, txn_hi = 0;
  logic [7:0] last_gain = 8'd0;
  int hs_cyc, n_dn, lat;
  logic [7:0]  cur_gain = 0, t_gain;
  logic [15:0] cur_phase = 0, t_phase;
  logic        cur_pd = 0, t_pd;
  logic [3:0]  cur_scale = 0, t_scale;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // monitor: every gain change pops one expected step
  always @(negedge clock) begin
    logic [39:0] e;
    if (!resetn) begin
      last_gain = 8'd0;
    end else begin
      if (mixer_gain !== last_gain) begin
        if (exp_q.size() == 0) begin
          chk("gain_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("gain_value", 32'(mixer_gain), 32'(e[7:0]));
          chk("gain_cycle", 32'(cyc), e[39:8]);
        end
        last_gain = mixer_gain;
      end
      if (cyc >= txn_lo && cyc < txn_hi && (busy !== 1'b1 || cfg_ready !== 1'b0))
        busy_bad++;
      if (scale_event === 1'b1) ev_cnt++;
    end
  end

  // driver tasks
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  function automatic int ceil_steps(input int g);
    return (g + STEP - 1) / STEP;
  endfunction

  task automatic send_cfg(input logic [7:0] g, input logic [15:0] ph, input logic pd,
                          input logic [3:0] sc);
    int budget, gm, m;
    cfg_gain = g; cfg_phase_inc = ph; cfg_pre_distortion = pd; cfg_scale = sc;
    cfg_valid = 1'b1;
    budget = 0;
    while (cfg_ready !== 1'b1 && budget < 5000) begin
      @(negedge clock);
      budget++;
    end
    chk("ready_wait", 32'(cfg_ready), 32'd1);
    hs_cyc = cyc + 1;
    n_dn = ceil_steps(int'(cur_gain));
    m = ceil_steps(int'(g));
    lat = 3 + (n_dn + m) * DIV;
    busy_bad = 0;
    txn_lo = hs_cyc;
    txn_hi = hs_cyc + lat;
    gm = int'(cur_gain);
    for (int k = 1; k <= n_dn; k++) begin
      gm = (gm > STEP) ? gm - STEP : 0;
      exp_q.push_back({32'(hs_cyc + k * DIV), 8'(gm)});
    end
    gm = 0;
    for (int k = 1; k <= m; k++) begin
      gm = (gm + STEP > int'(g)) ? int'(g) : gm + STEP;
      exp_q.push_back({32'(hs_cyc + n_dn * DIV + 2 + k * DIV), 8'(gm)});
    end
    t_gain = g; t_phase = ph; t_pd = pd; t_scale = sc;
    @(negedge clock);
    cfg_valid = 1'b0;
    chk("hs_busy_ready", {30'd0, busy, cfg_ready}, 32'b10);
  endtask

  task automatic finish_cfg();
    int apply_c, budget;
    apply_c = hs_cyc + n_dn * DIV + 2;
    wait_until(apply_c - 1);
    chk("pre_apply_phase", 32'(lo_dds_phase_inc), 32'(cur_phase));
    chk("apply_state", 32'(dbg_state), 32'(APPLY));
    wait_until(apply_c);
    chk("apply_phase", 32'(lo_dds_phase_inc), 32'(t_phase));
    chk("apply_pd", 32'(enable_pre_distortion), 32'(t_pd));
    chk("apply_scale", 32'(scale_select), 32'(t_scale));
    chk("apply_gain_zero", 32'(mixer_gain), 32'd0);
    budget = 0;
    while (cfg_ready !== 1'b1 && budget < lat + 50) begin
      @(negedge clock);
      budget++;
    end
    chk("ready_latency", 32'(cyc - hs_cyc), 32'(lat));
    chk("final_gain", 32'(mixer_gain), 32'(t_gain));
    chk("busy_hold", 32'(busy_bad), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    cur_gain = t_gain; cur_phase = t_phase; cur_pd = t_pd; cur_scale = t_scale;
  endtask

  initial begin
    int e;
    resetn = 1'b0; cfg_valid = 1'b0; cfg_gain = '0; cfg_phase_inc = '0;
    cfg_pre_distortion = 1'b0; cfg_scale = '0; interval_max = 16'd20000;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // reset values
    chk("rst_gain", 32'(mixer_gain), 32'd0);
    chk("rst_phase", 32'(lo_dds_phase_inc), 32'd0);
    chk("rst_pd", 32'(enable_pre_distortion), 32'd0);
    chk("rst_scale", 32'(scale_select), 32'd0);
    chk("rst_event", 32'(scale_event), 32'd0);
    chk("rst_busy_ready", {30'd0, busy, cfg_ready}, 32'b01);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // ramp 0 -> 0x40, 131-cycle turnaround
    send_cfg(8'h40, 16'h1234, 1'b1, 4'd3);
    finish_cfg();
    chk("t1_latency_131", 32'(lat), 32'd131);

    // 0x40 -> 0 -> 0x13 with clipped final step
    send_cfg(8'h13, 16'hBEEF, 1'b0, 4'd3);
    finish_cfg();

    // new request held valid while busy: taken only once cfg_ready returns
    send_cfg(8'h08, 16'h0101, 1'b1, 4'd2);
    cfg_gain = 8'h20; cfg_phase_inc = 16'h5555; cfg_pre_distortion = 1'b0; cfg_scale = 4'd3;
    cfg_valid = 1'b1;
    finish_cfg();
    send_cfg(8'h20, 16'h5555, 1'b0, 4'd3);
    finish_cfg();
    repeat (4) @(negedge clock);
    chk("one_hs_ready", 32'(cfg_ready), 32'd1);
    chk("one_hs_gain", 32'(mixer_gain), 32'h20);
    chk("one_hs_phase", 32'(lo_dds_phase_inc), 32'h5555);

    // sustained overload for three windows
    send_cfg(8'h20, 16'h2222, 1'b0, 4'd3);
    interval_max = 16'd31000;
    finish_cfg();
    e = cyc;
    wait_until(e + 3 * WL - 1);
    chk("ovl_scale_before", 32'(scale_select), 32'd3);
    chk("ovl_event_before", 32'(scale_event), 32'd0);
    wait_until(e + 3 * WL);
    chk("ovl_scale_after", 32'(scale_select), 32'(OVL_SCALE));
    chk("ovl_event_pulse", 32'(scale_event), 32'(OVL_EV));
    wait_until(e + 3 * WL + 1);
    chk("ovl_event_drop", 32'(scale_event), 32'd0);
    chk("ovl_event_count", 32'(ev_cnt), 32'(OVL_EV));
    interval_max = 16'd20000;

    // overload at the top code: no step, no pulse
    send_cfg(8'h20, 16'h3333, 1'b0, 4'd15);
    interval_max = 16'd31000;
    finish_cfg();
    e = cyc;
    wait_until(e + 4 * WL + 2);
    chk("max_scale_hold", 32'(scale_select), 32'd15);
    chk("max_no_event", 32'(ev_cnt), 32'(OVL_EV));
    interval_max = 16'd20000;

    // overload alternating with in-band windows
    send_cfg(8'h20, 16'h4444, 1'b0, 4'd5);
    finish_cfg();
    e = cyc;
    for (int w = 0; w < 6; w++) begin
      wait_until(e + w * WL);
      interval_max = (w % 2 == 0) ? 16'd31000 : 16'd20000;
    end
    wait_until(e + 6 * WL + 2);
    chk("alt_scale_hold", 32'(scale_select), 32'd5);
    chk("alt_no_event", 32'(ev_cnt), 32'(OVL_EV));
    interval_max = 16'd20000;

    // asynchronous reset in the middle of RAMP_UP
    send_cfg(8'h30, 16'h7777, 1'b1, 4'd6);
    wait_until(hs_cyc + n_dn * DIV + 2 + 40);
    chk("mid_up_state", 32'(dbg_state), 32'(RAMP_UP));
    chk("mid_up_gain", 32'(mixer_gain), 32'h10);
    chk("mid_up_phase", 32'(lo_dds_phase_inc), 32'h7777);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_gain", 32'(mixer_gain), 32'd0);
    chk("arst_phase", 32'(lo_dds_phase_inc), 32'd0);
    chk("arst_pd", 32'(enable_pre_distortion), 32'd0);
    chk("arst_scale", 32'(scale_select), 32'd0);
    chk("arst_event", 32'(scale_event), 32'd0);
    chk("arst_busy_ready", {30'd0, busy, cfg_ready}, 32'b01);
    exp_q.delete();
    txn_hi = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("rel_ready", 32'(cfg_ready), 32'd1);
    chk("rel_state", 32'(dbg_state), 32'(IDLE));
    cur_gain = 0; cur_phase = 0; cur_pd = 0; cur_scale = 0;

    // recovery after reset
    send_cfg(8'h08, 16'h0001, 1'b0, 4'd0);
    finish_cfg();
    chk("recover_latency_19", 32'(lat), 32'd19);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
